// File: rtl/conv_maxpool.sv
// conv_maxpool: 2x2 / stride-2 max pooling over a 3-channel raster pixel stream.
// Holds one row of horizontal pair maxima per channel and emits one pooled pixel per 2x2 window.
`default_nettype none

module conv_maxpool #(
  parameter int DW = 8,
  parameter int W  = 6,
  parameter int H  = 6,
  localparam int NPOOL = W * H / 4,
  localparam int IW    = (NPOOL > 1) ? $clog2(NPOOL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          px_vld,
  input  logic [DW-1:0] px_D1,
  input  logic [DW-1:0] px_D2,
  input  logic [DW-1:0] px_D3,
  output logic          pool_vld,
  output logic [IW-1:0] pool_idx,
  output logic [DW-1:0] pool_D1,
  output logic [DW-1:0] pool_D2,
  output logic [DW-1:0] pool_D3,
  output logic          frame_done,
  output logic          busy
);

  localparam int NCH = 3;
  localparam int HW  = W / 2;
  localparam int CW  = (W > 1) ? $clog2(W) : 1;
  localparam int RW  = (H > 1) ? $clog2(H) : 1;
  localparam int LBW = (HW > 1) ? $clog2(HW) : 1;

  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic           r_busy;
  logic [DW-1:0]  r_hold [NCH];
  logic [DW-1:0]  r_lb   [NCH][HW];
  logic [DW-1:0]  r_pool [NCH];
  logic [IW-1:0]  r_idx;
  logic           r_vld;
  logic           r_done;

  logic [CW-1:0]  w_col;
  logic [RW-1:0]  w_row;
  logic [CW-1:0]  w_col_nxt;
  logic [RW-1:0]  w_row_nxt;
  logic           w_last_col;
  logic           w_last_row;
  logic           w_last_px;
  logic           w_emit;
  logic           w_lb_wr;
  logic [LBW-1:0] w_half;
  logic [IW-1:0]  w_pidx;
  logic [DW-1:0]  w_px   [NCH];
  logic [DW-1:0]  w_hmax [NCH];
  logic [DW-1:0]  w_pmax [NCH];

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  // A pixel arriving together with frame_start is taken as (0,0) of the new frame.
  always_comb begin
    w_col      = frame_start ? '0 : r_col;
    w_row      = frame_start ? '0 : r_row;
    w_last_col = (w_col == CW'(W - 1));
    w_last_row = (w_row == RW'(H - 1));
    w_last_px  = w_last_col && w_last_row;
    w_col_nxt  = w_last_col ? '0 : w_col + 1'b1;
    w_row_nxt  = w_last_col ? (w_last_row ? '0 : w_row + 1'b1) : w_row;
    w_emit     = px_vld && w_col[0] && w_row[0];
    w_lb_wr    = px_vld && w_col[0] && !w_row[0];
    w_half     = LBW'(w_col >> 1);
    w_pidx     = IW'((int'(w_row) >> 1) * HW + (int'(w_col) >> 1));
  end

  assign w_px[0] = px_D1;
  assign w_px[1] = px_D2;
  assign w_px[2] = px_D3;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_hmax[c] = umax(r_hold[c], w_px[c]);
      w_pmax[c] = umax(r_lb[c][w_half], w_hmax[c]);
    end
  end

  // Raster position and frame-in-progress flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_busy <= 1'b0;
    end else if (px_vld) begin
      r_col  <= w_col_nxt;
      r_row  <= w_row_nxt;
      r_busy <= !w_last_px;
    end else if (frame_start) begin
      r_col  <= '0;
      r_row  <= '0;
      r_busy <= 1'b0;
    end
  end

  // Even-column hold registers and even-row line buffer of pair maxima.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_hold[c] <= '0;
        for (int i = 0; i < HW; i++) begin
          r_lb[c][i] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (px_vld && !w_col[0]) begin
          r_hold[c] <= w_px[c];
        end
        if (w_lb_wr) begin
          r_lb[c][w_half] <= w_hmax[c];
        end
      end
    end
  end

  // Pooled result register: data and index hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_done <= 1'b0;
      r_idx  <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_pool[c] <= '0;
      end
    end else begin
      r_vld  <= w_emit;
      r_done <= w_emit && w_last_px;
      if (w_emit) begin
        r_idx <= w_pidx;
        for (int c = 0; c < NCH; c++) begin
          r_pool[c] <= w_pmax[c];
        end
      end
    end
  end

  assign pool_vld   = r_vld;
  assign pool_idx   = r_idx;
  assign pool_D1    = r_pool[0];
  assign pool_D2    = r_pool[1];
  assign pool_D3    = r_pool[2];
  assign frame_done = r_done;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_conv_maxpool.sv
// tb_conv_maxpool: self-checking bench for conv_maxpool against a whole-frame reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_conv_maxpool;

  localparam int DW = 8;
  localparam int W  = 6;
  localparam int H  = 6;
  localparam int NP = W * H / 4;
  localparam int IW = $clog2(NP);

  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic          px_vld;
  logic [DW-1:0] px_D1, px_D2, px_D3;
  logic          pool_vld;
  logic [IW-1:0] pool_idx;
  logic [DW-1:0] pool_D1, pool_D2, pool_D3;
  logic          frame_done;
  logic          busy;

  conv_maxpool #(.DW(DW), .W(W), .H(H)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .px_vld(px_vld),
    .px_D1(px_D1), .px_D2(px_D2), .px_D3(px_D3),
    .pool_vld(pool_vld), .pool_idx(pool_idx),
    .pool_D1(pool_D1), .pool_D2(pool_D2), .pool_D3(pool_D3),
    .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int d1;
    int d2;
    int d3;
    bit done;
  } pool_rec_t;

  int errors = 0;
  int checks = 0;
  pool_rec_t got[$];

  // Reference model: the whole frame is kept as a pixel array and each
  // pooled value is the max over its 2x2 window.
  int pix [3][H][W];
  int mr, mc;
  bit m_vld, m_done, m_busy;
  int m_idx;
  int m_d [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; m_vld = 0; m_done = 0; m_busy = 0; m_idx = 0;
    for (int c = 0; c < 3; c++) m_d[c] = 0;
  endtask

  task automatic model_step(input bit v, input bit fs, input int a, input int b, input int c3);
    int best;
    m_vld = 0;
    m_done = 0;
    if (v) begin
      if (fs) begin mr = 0; mc = 0; end
      pix[0][mr][mc] = a;
      pix[1][mr][mc] = b;
      pix[2][mr][mc] = c3;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        m_vld = 1;
        m_idx = (mr / 2) * (W / 2) + mc / 2;
        for (int ch = 0; ch < 3; ch++) begin
          best = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (pix[ch][mr-dr][mc-dc] > best) best = pix[ch][mr-dr][mc-dc];
          m_d[ch] = best;
        end
        m_done = (m_idx == NP - 1);
      end
      m_busy = !((mr == H - 1) && (mc == W - 1));
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end else if (fs) begin
      mr = 0; mc = 0; m_busy = 0;
    end
  endtask

  task automatic check_outputs();
    chk("pool_vld", int'(pool_vld), int'(m_vld));
    chk("frame_done", int'(frame_done), int'(m_done));
    chk("busy", int'(busy), int'(m_busy));
    chk("pool_idx", int'(pool_idx), m_idx);
    chk("pool_D1", int'(pool_D1), m_d[0]);
    chk("pool_D2", int'(pool_D2), m_d[1]);
    chk("pool_D3", int'(pool_D3), m_d[2]);
    if (pool_vld)
      got.push_back('{int'(pool_idx), int'(pool_D1), int'(pool_D2), int'(pool_D3), frame_done});
  endtask

  // One clock cycle: drive, clock, update model, sample 1 ns after the edge.
  task automatic cycle(input bit v, input bit fs, input int a, input int b, input int c3);
    px_vld = v;
    frame_start = fs;
    px_D1 = DW'(a);
    px_D2 = DW'(b);
    px_D3 = DW'(c3);
    @(posedge clk);
    model_step(v, fs, a, b, c3);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic rand_px(input int n, input int gapmax);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, gapmax));
      cycle(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
  endtask

  // mode 0: ramp / inverse ramp / constant; mode 1: random; mode 2..5: single 200 in a window-0 corner
  task automatic run_frame(input int mode, input int gapmax);
    int a, b, c3;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        idle($urandom_range(0, gapmax));
        if (mode == 0) begin
          a = W * r + c; b = 255 - a; c3 = 42;
        end else if (mode == 1) begin
          a = $urandom_range(0, 255); b = $urandom_range(0, 255); c3 = $urandom_range(0, 255);
        end else begin
          a = (r == (mode - 2) / 2 && c == (mode - 2) % 2) ? 200 : 0; b = 0; c3 = 0;
        end
        cycle(1, 0, a, b, c3);
      end
    end
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    px_vld = 1'b0;
    frame_start = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  pool_rec_t tab [NP];

  initial begin
    int nd;
    tab[0] = '{0, 7, 255, 42, 0};
    tab[1] = '{1, 9, 253, 42, 0};
    tab[2] = '{2, 11, 251, 42, 0};
    tab[3] = '{3, 19, 243, 42, 0};
    tab[4] = '{4, 21, 241, 42, 0};
    tab[5] = '{5, 23, 239, 42, 0};
    tab[6] = '{6, 31, 231, 42, 0};
    tab[7] = '{7, 33, 229, 42, 0};
    tab[8] = '{8, 35, 227, 42, 1};

    rst_n = 1'b0;
    px_vld = 1'b0;
    frame_start = 1'b0;
    px_D1 = '0; px_D2 = '0; px_D3 = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < H; r++)
        for (int k = 0; k < W; k++) pix[c][r][k] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    idle(2);

    // Ramp with per-channel independence, compared against the fixed table.
    got.delete();
    run_frame(0, 0);
    idle(1);
    chk("ramp_count", got.size(), NP);
    for (int i = 0; i < NP; i++) begin
      if (i < got.size()) begin
        chk("tab_idx", got[i].idx, tab[i].idx);
        chk("tab_D1", got[i].d1, tab[i].d1);
        chk("tab_D2", got[i].d2, tab[i].d2);
        chk("tab_D3", got[i].d3, tab[i].d3);
        chk("tab_done", int'(got[i].done), int'(tab[i].done));
      end
    end

    // Single maximum in each corner of window 0.
    for (int m = 2; m <= 5; m++) begin
      got.delete();
      run_frame(m, 0);
      chk("corner_count", got.size(), NP);
      if (got.size() > 0) chk("corner_D1", got[0].d1, 200);
    end

    // Random data with random valid gaps.
    for (int f = 0; f < 3; f++) run_frame(1, 5);
    idle(3);

    // frame_start alone mid-frame, partial new frame restarted, then a full frame.
    rand_px(14, 2);
    cycle(0, 1, 0, 0, 0);
    rand_px(7, 2);
    cycle(0, 1, 0, 0, 0);
    run_frame(1, 1);
    // frame_start coincident with the first pixel of a frame.
    rand_px(9, 1);
    cycle(1, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    rand_px(W * H - 1, 1);
    idle(2);

    // Asynchronous reset mid-frame, then a clean frame.
    rand_px(20, 1);
    async_reset();
    got.delete();
    idle(2);
    chk("no_stale_out", got.size(), 0);
    run_frame(1, 2);

    // Back-to-back frames without frame_start.
    got.delete();
    run_frame(0, 0);
    run_frame(1, 0);
    idle(1);
    nd = 0;
    foreach (got[i]) if (got[i].done) nd++;
    chk("b2b_vld_count", got.size(), 2 * NP);
    chk("b2b_done_count", nd, 2);
    if (got.size() > NP) chk("b2b_idx_restart", got[NP].idx, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
